// File: rtl/lut_arbiter.sv
// lut_arbiter: round-robin sharing of the single lut_module read port
// between NUM_REQ requesters, one outstanding LUT transaction at a time.
// Results return to the issuing requester with a one-hot response strobe.
// Optional feature macro: LUT_ARB_TIMEOUT_EN (WAIT-state timeout with rsp_err).
module lut_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          busy,
  output logic                          lut_start,
  output logic [ADDR_WIDTH-1:0]         lut_addr,
  input  logic [DATA_WIDTH-1:0]         lut_data,
  input  logic                          lut_done
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned SUM_W = PTR_W + 1;

  // Elaboration-time parameter sanity checks
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("lut_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("lut_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;

`ifdef LUT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;
`endif

  logic [PTR_W-1:0]      winner;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [SUM_W-1:0]      scan_idx;
  logic [PTR_W-1:0]      ptr_next;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Winner search: first asserted req from rr_ptr upward, wrapping; descending
  // scan so the smallest offset is written last and wins.
  always_comb begin
    winner   = '0;
    win_addr = '0;
    scan_idx = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      scan_idx = SUM_W'(rr_ptr) + SUM_W'(off);
      if (scan_idx >= SUM_W'(NUM_REQ)) begin
        scan_idx = scan_idx - SUM_W'(NUM_REQ);
      end
      if (req[scan_idx[PTR_W-1:0]]) begin
        winner = scan_idx[PTR_W-1:0];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PTR_W'(i)) begin
        win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Pointer advances past the current owner, wrapping at NUM_REQ-1
  always_comb begin
    ptr_next = owner + PTR_W'(1);
    if (owner == PTR_W'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end
  end

  // Arbiter FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      lut_start <= 1'b0;
      lut_addr  <= '0;
`ifdef LUT_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      lut_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner     <= winner;
            lut_addr  <= win_addr;
            gnt       <= onehot(winner);
            lut_start <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rr_ptr   <= ptr_next;
          state    <= S_WAIT;
`ifdef LUT_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (lut_done) begin
            rsp_data  <= lut_data;
            rsp_err   <= 1'b0;
            rsp_valid <= onehot(owner);
            state     <= S_RESP;
          end
`ifdef LUT_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Limit reached without lut_done: abandon with an error response
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= onehot(owner);
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        S_RESP: begin
          rsp_err <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_arbiter.sv
// Directed self-checking bench for lut_arbiter (NUM_REQ=4, 8-bit addr/data).
module tb_lut_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_addr;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        lut_start;
  logic [7:0]  lut_addr;
  logic [7:0]  lut_data;
  logic        lut_done;

  int n_cmp;
  int n_err;

  // Auto-responder controls
  bit         auto_en;
  int         auto_dly;
  logic [7:0] auto_data;
  int         pend;

  lut_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .lut_start(lut_start),
    .lut_addr(lut_addr), .lut_data(lut_data), .lut_done(lut_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Answers each lut_start with lut_done auto_dly cycles later
  initial begin
    pend = 0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_en) begin
        lut_done = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            lut_done = 1'b1;
            lut_data = auto_data;
          end
        end
        if (lut_start) pend = auto_dly;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    auto_en  = 1'b0;
    pend     = 0;
    lut_done = 1'b0;
    req      = '0;
    rst_n    = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    req      = '0;
    lut_done = 1'b0;
    repeat (2) tick();
    n_cmp++; if ({gnt, rsp_valid, rsp_data, rsp_err, busy, lut_start, lut_addr} !== 27'd0) begin
      n_err++; $display("FAIL reset_outputs got %h expected 0",
        {gnt, rsp_valid, rsp_data, rsp_err, busy, lut_start, lut_addr});
    end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got %b expected 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    req_addr = {8'h00, 8'h09, 8'h00, 8'h00};
    req      = 4'b0100;
    tick();
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt got %b expected 0100", gnt); end
    n_cmp++; if (lut_start !== 1'b1) begin n_err++; $display("FAIL single_start got %b expected 1", lut_start); end
    n_cmp++; if (lut_addr !== 8'h09) begin n_err++; $display("FAIL single_addr got %h expected 09", lut_addr); end
    req      = '0;
    req_addr = '1;
    tick();
    n_cmp++; if ({gnt, lut_start} !== 5'b0) begin n_err++; $display("FAIL single_pulse got %b expected 0", {gnt, lut_start}); end
    n_cmp++; if (lut_addr !== 8'h09) begin n_err++; $display("FAIL single_addr_hold got %h expected 09", lut_addr); end
    tick();
    tick();
    lut_done = 1'b1;
    lut_data = 8'hA5;
    tick();
    lut_done = 1'b0;
    n_cmp++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL single_rsp_valid got %b expected 0100", rsp_valid); end
    n_cmp++; if (rsp_data !== 8'hA5) begin n_err++; $display("FAIL single_rsp_data got %h expected a5", rsp_data); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL single_rsp_err got %b expected 0", rsp_err); end
    tick();
    n_cmp++; if ({rsp_valid, busy} !== 5'b0) begin n_err++; $display("FAIL single_idle got %b expected 0", {rsp_valid, busy}); end
    n_cmp++; if (rsp_data !== 8'hA5) begin n_err++; $display("FAIL single_data_hold got %h expected a5", rsp_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_order [5];
    logic [3:0] last_g;
    int ng, ns, c0, c1;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ng = 0; ns = 0; c0 = 0; c1 = 0; last_g = '0;
    req_addr  = {8'h0D, 8'h0C, 8'h0B, 8'h0A};
    auto_en   = 1'b0;
    lut_done  = 1'b0;
    rst_n     = 1'b0;
    req       = 4'hF;
    repeat (2) tick();
    auto_dly  = 1;
    auto_data = 8'h5A;
    auto_en   = 1'b1;
    rst_n     = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (lut_start) ns++;
      if (rsp_valid !== 4'b0000) begin
        n_cmp++; if (rsp_valid !== last_g) begin n_err++; $display("FAIL rr_rsp_owner got %b expected %b", rsp_valid, last_g); end
      end
      if (gnt !== 4'b0000) begin
        n_cmp++; if (!$onehot(gnt)) begin n_err++; $display("FAIL rr_onehot got %b expected one-hot", gnt); end
        if (ng < 5) begin
          n_cmp++; if (gnt !== exp_order[ng]) begin n_err++; $display("FAIL rr_order[%0d] got %b expected %b", ng, gnt, exp_order[ng]); end
          n_cmp++; if (lut_addr !== 8'h0A + 8'(ng % 4)) begin n_err++; $display("FAIL rr_addr[%0d] got %h expected %h", ng, lut_addr, 8'h0A + 8'(ng % 4)); end
        end
        if (ng == 0) c0 = cyc;
        if (ng == 1) c1 = cyc;
        last_g = gnt;
        ng++;
      end
    end
    n_cmp++; if (ng < 5) begin n_err++; $display("FAIL rr_grant_count got %0d expected >=5", ng); end
    n_cmp++; if (ns !== ng) begin n_err++; $display("FAIL rr_start_count got %0d expected %0d", ns, ng); end
    n_cmp++; if (c1 - c0 !== 4) begin n_err++; $display("FAIL rr_spacing got %0d expected 4", c1 - c0); end
    do_reset();
  endtask

  task automatic test_fairness();
    logic [3:0] seen [3];
    int ng;
    ng = 0;
    seen = '{4'b0, 4'b0, 4'b0};
    do_reset();
    auto_dly  = 2;
    auto_data = 8'h11;
    auto_en   = 1'b1;
    req       = 4'b0001;
    for (int cyc = 0; cyc < 60 && ng < 3; cyc++) begin
      tick();
      if (gnt !== 4'b0000) begin
        seen[ng] = gnt;
        if (ng == 0) req[3] = 1'b1;
        if (gnt[3]) req[3] = 1'b0;
        ng++;
      end
    end
    n_cmp++; if (seen[0] !== 4'b0001) begin n_err++; $display("FAIL fair_first got %b expected 0001", seen[0]); end
    n_cmp++; if (seen[1] !== 4'b1000) begin n_err++; $display("FAIL fair_pending got %b expected 1000", seen[1]); end
    n_cmp++; if (seen[2] !== 4'b0001) begin n_err++; $display("FAIL fair_return got %b expected 0001", seen[2]); end
    do_reset();
  endtask

  task automatic test_spurious_done();
    int nrsp;
    nrsp = 0;
    do_reset();
    lut_done = 1'b1;
    lut_data = 8'hEE;
    tick();
    lut_done = 1'b0;
    n_cmp++; if ({rsp_valid, busy} !== 5'b0) begin n_err++; $display("FAIL spur_idle got %b expected 0", {rsp_valid, busy}); end
    req_addr = {8'h00, 8'h00, 8'h21, 8'h00};
    req      = 4'b0010;
    tick();
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL spur_gnt got %b expected 0010", gnt); end
    req      = '0;
    lut_done = 1'b1;
    tick();
    lut_done = 1'b0;
    n_cmp++; if ({rsp_valid, busy} !== 5'b00001) begin n_err++; $display("FAIL spur_issue got %b expected 00001", {rsp_valid, busy}); end
    tick();
    lut_done = 1'b1;
    lut_data = 8'h3C;
    tick();
    lut_done = 1'b0;
    n_cmp++; if (rsp_data !== 8'h3C) begin n_err++; $display("FAIL spur_data got %h expected 3c", rsp_data); end
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid === 4'b0010) nrsp++;
      tick();
    end
    n_cmp++; if (nrsp !== 1) begin n_err++; $display("FAIL spur_rsp_count got %0d expected 1", nrsp); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    req_addr = {8'h00, 8'h55, 8'h00, 8'h00};
    req      = 4'b0100;
    tick();
    req = '0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({gnt, rsp_valid, rsp_data, rsp_err, busy, lut_start, lut_addr} !== 27'd0) begin
      n_err++; $display("FAIL midwait_reset got %h expected 0",
        {gnt, rsp_valid, rsp_data, rsp_err, busy, lut_start, lut_addr});
    end
    tick();
    rst_n = 1'b1;
    lut_done = 1'b1;
    lut_data = 8'h77;
    tick();
    lut_done = 1'b0;
    tick();
    n_cmp++; if ({rsp_valid, busy} !== 5'b0) begin n_err++; $display("FAIL midwait_late_done got %b expected 0", {rsp_valid, busy}); end
    req_addr = {8'h44, 8'h00, 8'h22, 8'h00};
    req      = 4'b1010;
    tick();
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL midwait_ptr got %b expected 0010", gnt); end
    n_cmp++; if (lut_addr !== 8'h22) begin n_err++; $display("FAIL midwait_addr got %h expected 22", lut_addr); end
    do_reset();
  endtask

  task automatic test_timeout();
    do_reset();
    req_addr = {8'h00, 8'h00, 8'h00, 8'h31};
    req      = 4'b0001;
    tick();
    req = '0;
`ifdef LUT_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL to_early[%0d] got %b expected 0000", i, rsp_valid); end
    end
    tick();
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL to_valid got %b expected 0001", rsp_valid); end
    n_cmp++; if (rsp_err !== 1'b1) begin n_err++; $display("FAIL to_err got %b expected 1", rsp_err); end
    n_cmp++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL to_data got %h expected 00", rsp_data); end
    tick();
    n_cmp++; if ({rsp_err, busy} !== 2'b00) begin n_err++; $display("FAIL to_idle got %b expected 00", {rsp_err, busy}); end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++; if ({busy, rsp_valid, rsp_err} !== 6'b100000) begin
        n_err++; $display("FAIL no_to[%0d] got %b expected 100000", i, {busy, rsp_valid, rsp_err});
      end
    end
`endif
    do_reset();
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    auto_en   = 1'b0;
    auto_dly  = 1;
    auto_data = '0;
    rst_n     = 1'b0;
    req       = '0;
    req_addr  = '0;
    lut_data  = '0;
    lut_done  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_spurious_done();
    test_reset_mid_wait();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lut_arbiter.md
Name: lut_arbiter

Overview:
- Shares the single lut_module read port (start/addr -> data_o/done) between NUM_REQ independent requesters.
- Requesters include the parameter loaders and the runtime fetch paths of the transformer datapath.
- Uses round-robin arbitration and allows one outstanding LUT transaction at a time.
- Returns each result to the requester that issued it, with a per-requester response strobe.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 8, LUT address width
DATA_WIDTH, 8, LUT data width
TIMEOUT_CYCLES, 64, WAIT-state cycle limit; used only when LUT_ARB_TIMEOUT_EN is defined

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  request per requester; held with req_addr until gnt
req_addr  in  NUM_REQ*ADDR_WIDTH  flat address bus; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
gnt  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted
rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: rsp_data valid for that requester
rsp_data  out  DATA_WIDTH  shared response data
rsp_err  out  1  qualifies rsp_valid: transaction timed out
busy  out  1  high in every state except IDLE
lut_start  out  1  1-cycle start pulse to lut_module
lut_addr  out  ADDR_WIDTH  address to lut_module
lut_data  in  DATA_WIDTH  lut_module data_o
lut_done  in  1  lut_module done

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, rr_ptr=0, owner=0.
  - All outputs 0: gnt, rsp_valid, rsp_data, rsp_err, lut_start, lut_addr, busy.
- Reset mid-transaction aborts it with no response. A lut_done arriving after reset release is ignored in IDLE.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If |req, pick the winner: first asserted req scanning from index rr_ptr upward, wrapping modulo NUM_REQ.
  - Register owner=winner and lut_addr=req_addr[winner], then go to ISSUE.
  - No req: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - gnt[owner]=1 and lut_start=1 in this cycle.
  - rr_ptr <= (owner+1) mod NUM_REQ.
  - Go to WAIT.
- WAIT:
  - lut_start=0; lut_addr held stable.
  - On lut_done: capture lut_data and go to RESP.
  - lut_done is ignored in every state other than WAIT.
- RESP (exactly 1 cycle):
  - rsp_valid[owner]=1, rsp_data=captured data, rsp_err=0 (except on timeout).
  - Go to IDLE. rsp_data holds its value until the next RESP.
- Latency:
  - req sampled at edge k -> gnt/lut_start high in cycle k+1.
  - lut_done sampled at edge m -> rsp_valid high in cycle m+1.
  - Minimum spacing between grants is 4 cycles when lut_done returns in the first WAIT cycle.
- Requester rules:
  - A req deasserted before gnt is legal; req is sampled only in IDLE.
  - A req still high after gnt counts as a new request. It is re-arbitrated and the rotating pointer prevents starvation.
  - req_addr changes after the IDLE sample have no effect on the current transaction.
- Simultaneous requests: exactly one gnt bit per transaction. Each requester waits at most NUM_REQ-1 transactions.
- rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: LUT_ARB_TIMEOUT_EN.
- Defined:
  - 8-bit-or-wider wait counter, cleared on entry to WAIT and incremented each WAIT cycle without lut_done.
  - When the count reaches TIMEOUT_CYCLES: go to RESP with rsp_err=1 and rsp_data=0.
  - lut_done in the same cycle as the limit takes priority: normal response, rsp_err=0.
- Not defined:
  - No counter; WAIT lasts indefinitely until lut_done.
  - rsp_err is constant 0.

Test Plan:
1. Single request: req[2]=1, req_addr slot 2=8'h09, lut_done 3 cycles after lut_start with lut_data=8'hA5 -> gnt=4'b0100 and lut_start with lut_addr=8'h09 in the same cycle; rsp_valid=4'b0100, rsp_data=8'hA5 one cycle after lut_done.
2. All four req held high from reset -> grant order 0,1,2,3,0; each gnt is one-hot; lut_start count equals gnt count.
3. Fairness: req[0] held permanently, req[3] pulsed on -> req[3] is granted within 1 transaction after req[0]'s current one; req[0] is never granted twice in a row while req[3] is pending.
4. Spurious lut_done in IDLE and in ISSUE -> no rsp_valid, no state change; the real lut_done in WAIT produces exactly one rsp_valid.
5. rst_n asserted during WAIT -> all outputs 0 immediately; after release a late lut_done gives no rsp_valid; the next req[1] is granted with rr_ptr back at 0.
6. With LUT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, lut_done never arrives -> rsp_valid[owner]=1, rsp_err=1, rsp_data=0 eight cycles after entering WAIT. Without the macro: busy stays 1 and no rsp_valid is produced.
